mul_sched: RTL and testbench
============================

# mul_sched

Sequencer and two-way arbiter for the ALU's shared shift-add sequential multiplier datapath. Two requesters share the one multiplier. The block grants the datapath to one of them and drives the load/add/shift controls for a full WIDTH-bit multiply. It counts iterations internally, so the datapath needs no external "less than WIDTH" flag, and it signals completion to the granted requester. It sits between the ALU operation decode (the requesters) and the multiplier register/adder datapath.

## Interface
- WIDTH, 32: operand width; number of add/shift iterations per multiply.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- req  in  2  per-requester request level; held high until that requester's done pulse.
- mlsb  in  1  current LSB of the datapath multiplier register.
- gnt  out  2  one-hot grant; also the datapath operand-mux select; 0 when idle.
- load  out  1  datapath loads the granted operands and clears the product high half.
- add  out  1  datapath adds the multiplicand into the product high half.
- shr  out  1  datapath shifts the product/multiplier pair right by 1.
- busy  out  1  high in every state except IDLE.
- done  out  2  one-cycle pulse to the granted requester; the product is valid in this cycle.
- iter  out  CNT_W  completed-iteration count, for debug.

## Operation
- States: IDLE, LOAD, CALC, SHIFT, DONE.
- IDLE:
  - All outputs 0.
  - If req != 0, arbitrate, register gnt, and go to LOAD.
  - req is sampled only in IDLE.
- LOAD:
  - load=1, iter cleared to 0.
  - Go to CALC.
- CALC:
  - add = mlsb.
  - Go to SHIFT.
- SHIFT:
  - shr=1.
  - If iter == WIDTH-1, go to DONE; otherwise increment iter and go to CALC.
- DONE:
  - done[i]=1 for the granted i; gnt is still held.
  - Update the last-served pointer and go to IDLE, where gnt clears.
- gnt is constant from LOAD through DONE. load, add and shr are never asserted together.
- Arbitration with MUL_SCHED_RR_EN defined: see Configuration.
- req deasserted mid-operation: ignored. The multiply completes and done still pulses.
- req still high in the IDLE cycle after done: treated as a new request.
- req = 2'b00 in IDLE: stay in IDLE.
- rst high at any edge, including mid-operation:
  - Next state is IDLE; gnt, load, add, shr, busy, done and iter all become 0.
  - The last-served pointer is set to 1, so requester 0 wins the first tie.
  - rst takes priority over every transition.

## Timing
- Edge E0 samples req != 0 in IDLE. Counting cycles from E0:
  - Cycle 1: LOAD.
  - Cycles 2 .. 2*WIDTH+1: CALC and SHIFT alternate, CALC first.
  - Cycle 2*WIDTH+2: DONE.
  - Cycle 2*WIDTH+3: IDLE.
- WIDTH=32: done pulses in cycle 66; the earliest next grant is sampled at the end of cycle 67.
- Outputs are pure functions of registered state/grant, except add, which is combinational on mlsb in CALC.
- Exactly WIDTH shr pulses per operation; iter reads WIDTH-1 during the final SHIFT.

## Configuration
- MUL_SCHED_RR_EN defined: round-robin arbitration.
  - On a tie (req = 2'b11), grant the requester that was not last served.
  - A single request is granted directly.
- MUL_SCHED_RR_EN undefined: fixed priority, req[0] over req[1].
  - The last-served pointer is not implemented.
- All other behaviour is identical in both builds.

## Test plan
- Reset mid-op:
  - Stimulus: rst asserted in cycle 10 of an operation.
  - Required: next cycle shows busy=0, gnt=0, iter=0, and no done pulse. A following req=2'b01 with operands 2 and 2 completes with 4 after a full 66 cycles.
- Single request:
  - Stimulus: req=2'b01; the bench datapath model has multiplicand 3, multiplier 5.
  - Required: load in cycle 1; add high only in the CALC cycles where mlsb=1 (iterations 0 and 2); 32 shr pulses; done=2'b01 in cycle 66 with product 15; IDLE in cycle 67.
- Tie with RR, back to back:
  - Stimulus: MUL_SCHED_RR_EN defined, req=2'b11 held throughout.
  - Required: grants alternate 01, 10, 01 across three operations, each 66 cycles plus one IDLE cycle.
- Tie without RR:
  - Stimulus: macro undefined, req=2'b11 held.
  - Required: gnt=2'b01 on every operation; done[1] never pulses.
- Drop request:
  - Stimulus: req=2'b10, then req dropped to 0 in cycle 5.
  - Required: operation continues; done=2'b10 in cycle 66; IDLE afterwards with no regrant.
- Boundary:
  - Stimulus: multiplier 0xFFFFFFFF, multiplicand 0xFFFFFFFF.
  - Required: add asserted in all 32 CALC cycles; product 0xFFFFFFFE00000001; iter reads 31 in the final SHIFT.

Source files
------------

// File: rtl/mul_sched_if.sv
// mul_sched_if: request/grant and datapath-control bundle between the
// multiply requesters/datapath (master) and the mul_sched sequencer (slave).
interface mul_sched_if #(
   parameter int unsigned CNT_W = 6
);
   logic [1:0]       req;
   logic             mlsb;
   logic [1:0]       gnt;
   logic             load;
   logic             add;
   logic             shr;
   logic             busy;
   logic [1:0]       done;
   logic [CNT_W-1:0] iter;

   // Requesters and datapath drive req/mlsb and consume the controls
   modport master (
      output req, mlsb,
      input  gnt, load, add, shr, busy, done, iter
   );

   // Sequencer consumes req/mlsb and drives the controls
   modport slave (
      input  req, mlsb,
      output gnt, load, add, shr, busy, done, iter
   );
endinterface

// File: rtl/mul_sched.sv
// mul_sched: two-way arbiter and load/add/shift sequencer for the shared
// shift-add multiplier. Round-robin tie-breaking is enabled by defining
// MUL_SCHED_RR_EN; otherwise requester 0 has fixed priority.
module mul_sched #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input logic         clk,
   input logic         rst,
   mul_sched_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CALC  = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int unsigned LAST_ITER = WIDTH - 1;

   state_t           state, state_nxt;
   logic [1:0]       gnt_q, gnt_nxt;
   logic [CNT_W-1:0] iter_q, iter_nxt;
   logic             load_q, load_nxt;
   logic             shr_q, shr_nxt;
   logic             busy_q, busy_nxt;
   logic [1:0]       done_q, done_nxt;
   logic [1:0]       arb;

`ifdef MUL_SCHED_RR_EN
   // 1 means requester 1 was served most recently
   logic             last_q, last_nxt;
`endif

   // Arbitration of the request level sampled in IDLE
   always_comb begin
      arb = 2'b00;
`ifdef MUL_SCHED_RR_EN
      if (bus.req == 2'b11) begin
         arb = last_q ? 2'b01 : 2'b10;
      end else begin
         arb = bus.req[0] ? 2'b01 : 2'b10;
      end
`else
      arb = bus.req[0] ? 2'b01 : 2'b10;
`endif
   end

   // Next-state, grant, iteration count and registered-output decode
   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt_q;
      iter_nxt  = iter_q;
`ifdef MUL_SCHED_RR_EN
      last_nxt  = last_q;
`endif
      case (state)
         IDLE: begin
            gnt_nxt  = 2'b00;
            iter_nxt = '0;
            if (bus.req != 2'b00) begin
               gnt_nxt   = arb;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            iter_nxt  = '0;
            state_nxt = CALC;
         end
         CALC: begin
            state_nxt = SHIFT;
         end
         SHIFT: begin
            if (iter_q == CNT_W'(LAST_ITER)) begin
               state_nxt = DONE;
            end else begin
               iter_nxt  = iter_q + CNT_W'(1);
               state_nxt = CALC;
            end
         end
         DONE: begin
            gnt_nxt   = 2'b00;
            iter_nxt  = '0;
            state_nxt = IDLE;
`ifdef MUL_SCHED_RR_EN
            last_nxt  = gnt_q[1];
`endif
         end
         default: begin
            gnt_nxt   = 2'b00;
            iter_nxt  = '0;
            state_nxt = IDLE;
         end
      endcase
      load_nxt = (state_nxt == LOAD);
      shr_nxt  = (state_nxt == SHIFT);
      busy_nxt = (state_nxt != IDLE);
      done_nxt = (state_nxt == DONE) ? gnt_nxt : 2'b00;
   end

   // State and registered-output update with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         gnt_q  <= 2'b00;
         iter_q <= '0;
         load_q <= 1'b0;
         shr_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 2'b00;
`ifdef MUL_SCHED_RR_EN
         last_q <= 1'b1;
`endif
      end else begin
         state  <= state_nxt;
         gnt_q  <= gnt_nxt;
         iter_q <= iter_nxt;
         load_q <= load_nxt;
         shr_q  <= shr_nxt;
         busy_q <= busy_nxt;
         done_q <= done_nxt;
`ifdef MUL_SCHED_RR_EN
         last_q <= last_nxt;
`endif
      end
   end

   assign bus.gnt  = gnt_q;
   assign bus.iter = iter_q;
   assign bus.load = load_q;
   assign bus.shr  = shr_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   // add follows the live multiplier LSB during CALC
   assign bus.add  = (state == CALC) & bus.mlsb;

endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: scoreboard bench for mul_sched with a shift-add datapath
// model; expected products come from plain multiplication and expected
// winners from an arbitration model of the request pattern.
module tb_mul_sched;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 6;

   typedef struct {
      logic [1:0]  mask;
      logic [63:0] prod;
      int          adds;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   mul_sched_if #(.CNT_W(CNT_W)) bus ();

   mul_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt = 0;
   exp_t exp_q[$];

   logic [31:0] a_op [2];   // multiplicand per requester
   logic [31:0] b_op [2];   // multiplier per requester
   int          last_served = 1;

   // Shift-add datapath driven by the sequencer controls
   logic [31:0] dp_m, dp_a, dp_q;
   logic        dp_c;
   assign bus.mlsb = dp_q[0];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.load) begin
         dp_m <= bus.gnt[1] ? a_op[1] : a_op[0];
         dp_q <= bus.gnt[1] ? b_op[1] : b_op[0];
         dp_a <= 32'd0;
         dp_c <= 1'b0;
      end else if (bus.add) begin
         {dp_c, dp_a} <= {1'b0, dp_a} + {1'b0, dp_m};
      end else if (bus.shr) begin
         {dp_a, dp_q} <= {dp_c, dp_a, dp_q[31:1]};
         dp_c <= 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   // Monitor: per-operation control tracking and scoreboard pop on done
   int         load_cyc, n_add, n_shr;
   logic [1:0] gnt_held;
   bit         in_op = 0, chk_idle = 0, excl_bad, gnt_bad, iter_bad;

   always @(negedge clk) begin
      if (rst) begin
         in_op    = 0;
         chk_idle = 0;
      end else begin
         if (chk_idle) begin
            chk("idle_after_done", 64'({bus.busy, bus.gnt, bus.done, bus.iter}), 64'd0);
            chk_idle = 0;
         end
         if (bus.load) begin
            in_op    = 1;
            load_cyc = cyc;
            gnt_held = bus.gnt;
            n_add    = 0;
            n_shr    = 0;
            excl_bad = 0;
            gnt_bad  = 0;
            iter_bad = 0;
         end
         if (in_op) begin
            if (int'(bus.load) + int'(bus.add) + int'(bus.shr) > 1) excl_bad = 1;
            if (bus.gnt != gnt_held || !bus.busy) gnt_bad = 1;
            if (bus.add) n_add++;
            if (bus.shr) begin
               if (int'(bus.iter) != n_shr) iter_bad = 1;
               n_shr++;
            end
         end
         if (bus.done != 2'b00) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 64'(bus.done), 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("done_mask", 64'(bus.done), 64'(e.mask));
               chk("product", {dp_a, dp_q}, e.prod);
               chk("latency", 64'(cyc - load_cyc), 64'(2 * WIDTH + 1));
               chk("shr_count", 64'(n_shr), 64'(WIDTH));
               chk("add_count", 64'(n_add), 64'(e.adds));
               chk("ctl_flags", 64'({excl_bad, gnt_bad, iter_bad}), 64'd0);
            end
            in_op    = 0;
            chk_idle = 1;
            done_cnt++;
         end
      end
   end

   // Expected winner of one operation for a held request pattern
   function automatic int pick(input logic [1:0] r);
      int w;
`ifdef MUL_SCHED_RR_EN
      if (r == 2'b11) w = (last_served == 1) ? 0 : 1;
      else            w = r[0] ? 0 : 1;
`else
      w = r[0] ? 0 : 1;
`endif
      last_served = w;
      return w;
   endfunction

   task automatic run_ops(input logic [1:0] r, input int n, input int drop);
      int target, lim, w;
      exp_t e;
      target = done_cnt + n;
      for (int k = 0; k < n; k++) begin
         w      = pick(r);
         e.mask = (w == 0) ? 2'b01 : 2'b10;
         e.prod = {32'd0, a_op[w]} * {32'd0, b_op[w]};
         e.adds = $countones(b_op[w]);
         exp_q.push_back(e);
      end
      bus.req = r;
      if (drop > 0) begin
         repeat (drop) @(negedge clk);
         #1 bus.req = 2'b00;
      end
      lim = 0;
      while (done_cnt < target && lim < 100 * n) begin
         @(negedge clk);
         #1 lim++;
      end
      bus.req = 2'b00;
      chk("op_timeout", 64'(done_cnt >= target), 64'd1);
   endtask

   initial begin
      rst     = 1'b1;
      bus.req = 2'b00;
      a_op[0] = 32'd0; a_op[1] = 32'd0;
      b_op[0] = 32'd0; b_op[1] = 32'd0;
      repeat (3) @(negedge clk);
      #1 chk("reset_state", 64'({bus.busy, bus.gnt, bus.done, bus.load, bus.shr, bus.iter}), 64'd0);
      rst = 1'b0;
      last_served = 1;
      repeat (2) @(negedge clk);
      #1;

      // Single request, 3 x 5
      a_op[0] = 32'd3; b_op[0] = 32'd5;
      run_ops(2'b01, 1, 0);

      // All-ones operands on requester 1
      a_op[1] = 32'hFFFF_FFFF; b_op[1] = 32'hFFFF_FFFF;
      run_ops(2'b10, 1, 0);

      // Held tie, three back-to-back operations
      a_op[0] = $urandom; b_op[0] = $urandom;
      a_op[1] = $urandom; b_op[1] = $urandom;
      run_ops(2'b11, 3, 0);

      // Request dropped early; operation still completes, no regrant
      a_op[1] = $urandom; b_op[1] = $urandom;
      run_ops(2'b10, 1, 5);
      begin
         int bad = 0;
         repeat (5) begin
            @(negedge clk);
            #1 if (bus.busy || bus.gnt != 2'b00) bad++;
         end
         chk("no_regrant", 64'(bad), 64'd0);
      end

      // Reset in the middle of an operation
      a_op[0] = $urandom; b_op[0] = $urandom;
      bus.req = 2'b01;
      repeat (10) @(negedge clk);
      #1 rst = 1'b1;
      bus.req = 2'b00;
      @(negedge clk);
      #1 chk("mid_reset", 64'({bus.busy, bus.gnt, bus.done, bus.iter}), 64'd0);
      rst = 1'b0;
      last_served = 1;
      @(negedge clk);
      #1;
      a_op[0] = 32'd2; b_op[0] = 32'd2;
      run_ops(2'b01, 1, 0);

      // Randomized request patterns and operands
      for (int t = 0; t < 6; t++) begin
         logic [1:0] r;
         r = 2'($urandom_range(1, 3));
         a_op[0] = $urandom; b_op[0] = $urandom;
         a_op[1] = $urandom; b_op[1] = $urandom;
         if (t == 0) b_op[0] = 32'd0;
         run_ops(r, int'($urandom_range(1, 2)), 0);
         repeat (int'($urandom_range(0, 3))) @(negedge clk);
         #1;
      end

      repeat (3) @(negedge clk);
      #1 chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
